ptw: RTL and testbench

// - Two-level page table walker serving TLB misses. Sits directly downstream of the TLB's PTW port.
// - Accepts a miss vaddr and reads the L1 and L2 PTEs over a single-outstanding memory read port.
// - Returns a TLB-format PTE: [31:12] PPN, [1:0] perms {W,R}, all other bits zero.
// - On any fault it returns perms=2'b00, so the TLB permission check faults the access.

---
 rtl/ptw_pkg.sv | 25 ++
 rtl/ptw_pte_decode.sv | 34 +++
 rtl/ptw.sv | 137 +++++++++++++
 tb/tb_ptw.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_pkg.sv
// rtl/ptw_pkg.sv - shared state encoding, PTE bit positions and PTE layout for the page table walker
package ptw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L2_REQ,
    L2_WAIT,
    RESP
  } ptw_state_t;

  localparam int PTE_R = 0;
  localparam int PTE_W = 1;
  localparam int PTE_V = 2;

  typedef struct packed {
    logic [19:0] ppn;
    logic [8:0]  rsvd;
    logic        v;
    logic        w;
    logic        r;
  } pte_t;

endpackage

// File: rtl/ptw_pte_decode.sv
// rtl/ptw_pte_decode.sv - classifies a memory PTE as pointer, leaf or fault at a given level
// Superpage leaves at level 1 are accepted only when PTW_SUPERPAGE_EN is defined.
module ptw_pte_decode
  import ptw_pkg::*;
(
  input  logic [31:0] pte,
  input  logic        level,
  output logic        is_ptr,
  output logic        is_leaf,
  output logic        fault
);

  pte_t p;
  logic has_perm;
  logic l1_leaf_ok;
  logic unused_bits;

  assign p           = pte;
  assign has_perm    = p.w | p.r;
  assign unused_bits = ^{p.rsvd, p.ppn};

`ifdef PTW_SUPERPAGE_EN
  // A 4 MiB superpage must be aligned: the low ten PPN bits come from vpn0.
  assign l1_leaf_ok = (p.ppn[9:0] == 10'd0);
`else
  assign l1_leaf_ok = 1'b0;
`endif

  // level=1 is the root table, level=0 the leaf table.
  assign fault   = !p.v || (level ? (has_perm && !l1_leaf_ok) : !has_perm);
  assign is_ptr  = level && p.v && !has_perm;
  assign is_leaf = p.v && has_perm && !fault;

endmodule

// File: rtl/ptw.sv
// rtl/ptw.sv - two-level page table walker with single-outstanding memory reads and per-read timeout
// Optional L1 superpage support is compiled in with PTW_SUPERPAGE_EN.
module ptw
  import ptw_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ptw_req_i,
  input  logic [31:0] ptw_vaddr_i,
  input  logic [19:0] satp_ppn_i,
  output logic        ptw_resp_valid_o,
  output logic [31:0] ptw_pte_o,
  output logic        ptw_fault_o,
  output logic        ptw_busy_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  ptw_state_t state, state_n;
  logic [19:0] vpn_q;
  logic [19:0] root_ppn_q;
  logic [19:0] l1_ppn_q;
  logic [TO_W-1:0] cnt_q;
  logic [31:0] pte_q;
  logic        fault_q;

  logic        dec_is_ptr, dec_is_leaf, dec_fault;
  logic        timed_out;
  logic        resp_load, l1_load;
  logic [31:0] resp_pte;
  logic        resp_fault;

  ptw_pte_decode u_decode (
    .pte     (mem_rdata_i),
    .level   (state == L1_WAIT),
    .is_ptr  (dec_is_ptr),
    .is_leaf (dec_is_leaf),
    .fault   (dec_fault)
  );

  assign timed_out = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n    = state;
    resp_load  = 1'b0;
    l1_load    = 1'b0;
    resp_pte   = 32'h0;
    resp_fault = 1'b0;
    case (state)
      IDLE:    if (ptw_req_i) state_n = L1_REQ;
      L1_REQ:  state_n = L1_WAIT;
      L1_WAIT: begin
        // rvalid is checked first so data arriving on the timeout cycle still wins.
        if (mem_rvalid_i) begin
          if (dec_fault) begin
            state_n    = RESP;
            resp_load  = 1'b1;
            resp_fault = 1'b1;
          end else if (dec_is_ptr) begin
            state_n = L2_REQ;
            l1_load = 1'b1;
          end else if (dec_is_leaf) begin
            state_n   = RESP;
            resp_load = 1'b1;
`ifdef PTW_SUPERPAGE_EN
            resp_pte  = {mem_rdata_i[31:22], vpn_q[9:0], 10'b0,
                         mem_rdata_i[PTE_W], mem_rdata_i[PTE_R]};
`else
            resp_fault = 1'b1;
`endif
          end
        end else if (timed_out) begin
          state_n    = RESP;
          resp_load  = 1'b1;
          resp_fault = 1'b1;
        end
      end
      L2_REQ:  state_n = L2_WAIT;
      L2_WAIT: begin
        if (mem_rvalid_i) begin
          state_n   = RESP;
          resp_load = 1'b1;
          if (dec_fault) resp_fault = 1'b1;
          else resp_pte = {mem_rdata_i[31:12], 10'b0, mem_rdata_i[PTE_W], mem_rdata_i[PTE_R]};
        end else if (timed_out) begin
          state_n    = RESP;
          resp_load  = 1'b1;
          resp_fault = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpn_q      <= '0;
      root_ppn_q <= '0;
      l1_ppn_q   <= '0;
      cnt_q      <= '0;
      pte_q      <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (state == IDLE && ptw_req_i) begin
        vpn_q      <= ptw_vaddr_i[31:12];
        root_ppn_q <= satp_ppn_i;
      end
      if (state == L1_REQ || state == L2_REQ) cnt_q <= '0;
      else if (state == L1_WAIT || state == L2_WAIT) cnt_q <= cnt_q + 1'b1;
      if (l1_load) l1_ppn_q <= mem_rdata_i[31:12];
      if (resp_load) begin
        pte_q   <= resp_pte;
        fault_q <= resp_fault;
      end
    end
  end

  assign ptw_resp_valid_o = (state == RESP);
  assign ptw_busy_o       = (state != IDLE);
  assign ptw_pte_o        = pte_q;
  assign ptw_fault_o      = fault_q;
  assign mem_req_o        = (state == L1_REQ) || (state == L2_REQ);
  assign mem_addr_o       = (state == L1_REQ) ? {root_ppn_q, vpn_q[19:10], 2'b00} :
                            (state == L2_REQ) ? {l1_ppn_q, vpn_q[9:0], 2'b00} : 32'h0;

endmodule

// File: tb/tb_ptw.sv
// tb/tb_ptw.sv - scoreboard bench for ptw: directed walks plus randomized walks against a reference model
module tb_ptw;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ptw_req_i = 1'b0;
  logic [31:0] ptw_vaddr_i = 32'h0;
  logic [19:0] satp_ppn_i = 20'h0;
  logic        ptw_resp_valid_o;
  logic [31:0] ptw_pte_o;
  logic        ptw_fault_o;
  logic        ptw_busy_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  ptw #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .ptw_req_i        (ptw_req_i),
    .ptw_vaddr_i      (ptw_vaddr_i),
    .satp_ppn_i       (satp_ppn_i),
    .ptw_resp_valid_o (ptw_resp_valid_o),
    .ptw_pte_o        (ptw_pte_o),
    .ptw_fault_o      (ptw_fault_o),
    .ptw_busy_o       (ptw_busy_o),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pte;
    logic        fault;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          dly;
  } rd_t;
  rd_t rd_q[$];

  bit          pend = 1'b0;
  int          pend_cyc = 0;
  logic [31:0] pend_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: delay d is the cycle after mem_req on which data returns; 0 or >T means it never arrives in time.
  function automatic void model(input logic [31:0] va, input logic [31:0] l1, input int d1,
                                input logic [31:0] l2, input int d2,
                                output logic [31:0] pte, output logic flt, output int lat, output bit two);
    pte = 32'h0;
    flt = 1'b1;
    two = 1'b0;
    if (d1 < 1 || d1 > T) begin lat = 2 + T; return; end
    lat = 2 + d1;
    if (!l1[2]) return;
    if (l1[1:0] == 2'b00) begin
      two = 1'b1;
      if (d2 < 1 || d2 > T) begin lat = 3 + d1 + T; return; end
      lat = 3 + d1 + d2;
      if (l2[2] && l2[1:0] != 2'b00) begin
        pte = {l2[31:12], 10'b0, l2[1:0]};
        flt = 1'b0;
      end
      return;
    end
`ifdef PTW_SUPERPAGE_EN
    if (l1[21:12] == 10'd0) begin
      pte = {l1[31:22], va[21:12], 10'b0, l1[1:0]};
      flt = 1'b0;
    end
`endif
  endfunction

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while ((ptw_busy_o || pend) && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (w >= 60) flag("idle_wait_expired");
  endtask

  task automatic walk(input logic [31:0] va, input logic [19:0] satp, input logic [31:0] l1, input int d1,
                      input logic [31:0] l2, input int d2, input bit dup);
    logic [31:0] pte;
    logic        flt;
    int          lat;
    bit          two;
    wait_idle();
    model(va, l1, d1, l2, d2, pte, flt, lat, two);
    rd_q.push_back('{addr: {satp, va[31:22], 2'b00}, data: l1, dly: d1});
    if (two) rd_q.push_back('{addr: {l1[31:12], va[21:12], 2'b00}, data: l2, dly: d2});
    exp_q.push_back('{pte: pte, fault: flt, due: cyc + lat});
    ptw_req_i   = 1'b1;
    ptw_vaddr_i = va;
    satp_ppn_i  = satp;
    @(negedge clk);
    ptw_req_i   = 1'b0;
    ptw_vaddr_i = $urandom;
    satp_ppn_i  = 20'($urandom);
    if (dup) begin
      @(negedge clk);
      ptw_req_i   = 1'b1;
      ptw_vaddr_i = $urandom;
      @(negedge clk);
      ptw_req_i   = 1'b0;
    end
  endtask

  function automatic logic [31:0] gen_l1();
    int k = $urandom_range(0, 9);
    logic [31:0] r = $urandom;
    logic [1:0] pm = 2'($urandom_range(1, 3));
    if (k < 2) return r & ~32'h4;
    if (k < 7) return (r & ~32'h7) | 32'h4;
    if (k < 9) return (r & 32'hFFC0_0FF8) | 32'h4 | {30'b0, pm};
    return (r & ~32'h7) | 32'h1004 | {30'b0, pm};
  endfunction

  function automatic logic [31:0] gen_l2();
    int k = $urandom_range(0, 9);
    logic [31:0] r = $urandom;
    logic [1:0] pm = 2'($urandom_range(1, 3));
    if (k < 2) return r & ~32'h4;
    if (k < 3) return (r & ~32'h7) | 32'h4;
    return (r & ~32'h7) | 32'h4 | {30'b0, pm};
  endfunction

  function automatic int gen_dly();
    int k = $urandom_range(0, 19);
    if (k == 0) return 0;
    if (k == 1) return T + 1 + $urandom_range(0, 1);
    return $urandom_range(1, T);
  endfunction

  // Memory responder: checks each read address and returns data after the scheduled delay.
  initial begin
    rd_t r;
    forever begin
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (pend && cyc == pend_cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = pend_data;
        pend         = 1'b0;
      end
      if (mem_req_o) begin
        if (rd_q.size() == 0) flag("unexpected_mem_req");
        else begin
          r = rd_q.pop_front();
          check("mem_addr", mem_addr_o, r.addr);
          if (r.dly > 0) begin
            pend      = 1'b1;
            pend_cyc  = cyc + r.dly;
            pend_data = r.data;
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ptw_resp_valid_o) begin
        if (exp_q.size() == 0) flag("unexpected_resp");
        else begin
          e = exp_q.pop_front();
          check("resp_pte", ptw_pte_o, e.pte);
          check("resp_fault", {31'b0, ptw_fault_o}, {31'b0, e.fault});
          check("resp_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'b0, ptw_resp_valid_o}, 32'h0);
    check("rst_busy", {31'b0, ptw_busy_o}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_pte", ptw_pte_o, 32'h0);
    check("rst_fault", {31'b0, ptw_fault_o}, 32'h0);
    rst = 1'b0;

    walk(32'h0040_3ABC, 20'h00010, 32'h0002_0004, 1, 32'h0ABC_D007, 1, 1'b0);
    wait_idle();
    check("basic_pte_held", ptw_pte_o, 32'h0ABC_D003);
    check("basic_fault_held", {31'b0, ptw_fault_o}, 32'h0);

    walk(32'h0040_3ABC, 20'h00010, 32'h0000_0000, 1, 32'h0, 0, 1'b0);
    walk(32'h0040_3ABC, 20'h00010, 32'h0002_0004, 1, 32'h0ABC_D004, 1, 1'b0);
    walk(32'h1234_5678, 20'h0ABCD, 32'h0002_0004, 0, 32'h0, 0, 1'b0);
    walk(32'h1234_5678, 20'h0ABCD, 32'h0002_0004, T + 1, 32'h0, 0, 1'b0);
    walk(32'h1234_5678, 20'h0ABCD, 32'h0002_0004, T, 32'h0003_3005, T, 1'b0);
    walk(32'h1234_5678, 20'h0ABCD, 32'h0002_0004, 2, 32'h0, 0, 1'b0);
    walk(32'hFFFF_FFFF, 20'hFFFFF, 32'hFFFF_F004, 1, 32'hFFFF_F007, 1, 1'b1);

    // Reset while the L2 read is outstanding; its data returns stale after reset.
    wait_idle();
    c0 = cyc;
    rd_q.push_back('{addr: 32'h0001_0004, data: 32'h0002_0004, dly: 1});
    rd_q.push_back('{addr: 32'h0002_000C, data: 32'h0ABC_D007, dly: T + 3});
    ptw_req_i   = 1'b1;
    ptw_vaddr_i = 32'h0040_3ABC;
    satp_ppn_i  = 20'h00010;
    @(negedge clk);
    ptw_req_i = 1'b0;
    while (cyc < c0 + 4) @(negedge clk);
    check("busy_in_l2_wait", {31'b0, ptw_busy_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_resp_valid", {31'b0, ptw_resp_valid_o}, 32'h0);
    check("midrst_busy", {31'b0, ptw_busy_o}, 32'h0);
    check("midrst_mem_req", {31'b0, mem_req_o}, 32'h0);
    check("midrst_mem_addr", mem_addr_o, 32'h0);
    check("midrst_pte", ptw_pte_o, 32'h0);
    check("midrst_fault", {31'b0, ptw_fault_o}, 32'h0);
    walk(32'h0040_3ABC, 20'h00010, 32'h0002_0004, 1, 32'h0ABC_D007, 1, 1'b0);

    walk(32'h0040_3ABC, 20'h00010, 32'h0C00_0007, 1, 32'h0, 0, 1'b0);
    wait_idle();
`ifdef PTW_SUPERPAGE_EN
    check("superpage_pte", ptw_pte_o, 32'h0C00_3003);
    check("superpage_fault", {31'b0, ptw_fault_o}, 32'h0);
`else
    check("superpage_pte", ptw_pte_o, 32'h0);
    check("superpage_fault", {31'b0, ptw_fault_o}, 32'h1);
`endif

    for (int i = 0; i < 80; i++) begin
      walk($urandom, 20'($urandom), gen_l1(), gen_dly(), gen_l2(), gen_dly(), ($urandom_range(0, 3) == 0));
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'h0);
    check("rd_q_drained", rd_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
